// File: rtl/fir_decimator.sv
// fir_decimator
//   Block-sum decimator behind a FIR filter. It sums DECIM consecutive valid
//   samples, shifts the sum right arithmetically by SHIFT and saturates it to
//   16 bits. The result goes into a first-word-fall-through output FIFO.
//   A result that arrives while the FIFO is full with no pop is dropped, and
//   the sticky ovf flag is set.
//
//   Optional macro FIR_DECIM_ROUND_EN: when defined, 2^(SHIFT-1) is added
//   before the shift, which rounds half up. When undefined, the result is
//   truncated toward negative infinity and no rounding adder is built.
//
//   Ports
//     clk      in   single clock, rising edge
//     rst      in   async active-low reset
//     x        in   16-bit signed sample
//     valid    in   x is valid this cycle
//     clr      in   synchronous flush of phase, accumulator, FIFO and ovf
//     m_data   out  16-bit signed sample at the FIFO head (0 when empty)
//     m_valid  out  FIFO non-empty
//     m_ready  in   downstream accepts m_data this cycle
//     level    out  FIFO occupancy
//     ovf      out  sticky drop flag
module fir_decimator #(
    parameter int DECIM = 4,
    parameter int SHIFT = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [15:0]         x,
    input  logic                       valid,
    input  logic                       clr,
    output logic signed [15:0]         m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf
);

    localparam int PW   = $clog2(DECIM);
    localparam int AW   = 17 + PW;
    localparam int PTRW = $clog2(DEPTH);
    localparam int LW   = PTRW + 1;

    localparam logic [PW-1:0]        LAST = PW'(DECIM - 1);
    localparam logic signed [AW-1:0] MAXV = AW'(32767);
    localparam logic signed [AW-1:0] MINV = AW'(-32768);

    logic [PW-1:0]          phase;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   x_ext;
    logic signed [AW-1:0]   sum;
    logic signed [AW-1:0]   rsum;
    logic signed [AW-1:0]   shifted;
    logic signed [15:0]     result;

    logic signed [15:0]     mem [DEPTH];
    logic [PTRW-1:0]        wr_ptr;
    logic [PTRW-1:0]        rd_ptr;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   do_write;
    logic                   drop;

    assign x_ext = {{(AW-16){x[15]}}, x};
    assign sum   = acc + x_ext;

`ifdef FIR_DECIM_ROUND_EN
    localparam logic signed [AW-1:0] RND = (SHIFT > 0) ? AW'(1 << (SHIFT - 1)) : '0;
    assign rsum = sum + RND;
`else
    assign rsum = sum;
`endif

    assign shifted = rsum >>> SHIFT;

    always_comb begin
        result = shifted[15:0];
        if (shifted > MAXV)
            result = 16'sh7fff;
        else if (shifted < MINV)
            result = 16'sh8000;
    end

    // FIFO control. clr masks every push and pop on its edge.
    // A push into a full FIFO still succeeds when a pop frees the head
    // slot on the same edge.
    assign m_valid  = (level != '0);
    assign full     = (level == LW'(DEPTH));
    assign push     = valid && (phase == LAST) && !clr;
    assign pop      = m_valid && m_ready && !clr;
    assign do_write = push && (!full || pop);
    assign drop     = push && full && !pop;

    assign m_data = m_valid ? mem[rd_ptr] : 16'sd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
            acc   <= '0;
        end else if (clr) begin
            phase <= '0;
            acc   <= '0;
        end else if (valid) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
            // Phase 0 starts a new block, so x replaces the old sum.
            acc   <= (phase == '0) ? x_ext : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTRW'(1);
            if (do_write && !pop)
                level <= level + LW'(1);
            else if (pop && !do_write)
                level <= level - LW'(1);
            if (drop)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
module tb_fir_decimator;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] x;
    logic               valid;
    logic               clr;
    logic signed [15:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic [3:0]         level;
    logic               ovf;

    logic signed [15:0] x2;
    logic               valid2;
    logic signed [15:0] m_data2;
    logic               m_valid2;
    logic               m_ready2;
    logic [3:0]         level2;
    logic               ovf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_decimator dut (
        .clk(clk), .rst(rst), .x(x), .valid(valid), .clr(clr),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .ovf(ovf)
    );

    fir_decimator #(.DECIM(4), .SHIFT(0), .DEPTH(8)) u_sat (
        .clk(clk), .rst(rst), .x(x2), .valid(valid2), .clr(clr),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
        .level(level2), .ovf(ovf2)
    );

    typedef struct {
        logic        v;
        int          xin;
        logic        rdy;
        logic        ev;
        int          ed;
        int          el;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // inputs change 1 time unit after a rising edge; outputs are read there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int a, input int b, input int c, input int d);
        int s[4];
        s = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            x = 16'(s[i]); valid = 1'b1;
            step();
        end
        valid = 1'b0; x = '0;
    endtask

    int r1, r2, r3;

    initial begin
`ifdef FIR_DECIM_ROUND_EN
        r1 = 3; r2 = 7; r3 = -2;
`else
        r1 = 2; r2 = 6; r3 = -3;
`endif
        // consecutive 1..8, then 1..4 with gaps, then -1..-4
        vecs[0]  = '{1, 1, 1, 0, 0, 0};
        vecs[1]  = '{1, 2, 1, 0, 0, 0};
        vecs[2]  = '{1, 3, 1, 0, 0, 0};
        vecs[3]  = '{1, 4, 1, 1, r1, 1};
        vecs[4]  = '{1, 5, 1, 0, 0, 0};
        vecs[5]  = '{1, 6, 1, 0, 0, 0};
        vecs[6]  = '{1, 7, 1, 0, 0, 0};
        vecs[7]  = '{1, 8, 1, 1, r2, 1};
        vecs[8]  = '{0, 0, 1, 0, 0, 0};
        vecs[9]  = '{1, 1, 1, 0, 0, 0};
        vecs[10] = '{0, 9, 1, 0, 0, 0};
        vecs[11] = '{1, 2, 1, 0, 0, 0};
        vecs[12] = '{0, 9, 1, 0, 0, 0};
        vecs[13] = '{1, 3, 1, 0, 0, 0};
        vecs[14] = '{0, 9, 1, 0, 0, 0};
        vecs[15] = '{1, 4, 1, 1, r1, 1};
        vecs[16] = '{0, 0, 1, 0, 0, 0};
        vecs[17] = '{1, -1, 1, 0, 0, 0};
        vecs[18] = '{1, -2, 1, 0, 0, 0};
        vecs[19] = '{1, -3, 1, 0, 0, 0};
        vecs[20] = '{1, -4, 1, 1, r3, 1};
        vecs[21] = '{0, 0, 1, 0, 0, 0};

        rst = 1'b0; x = '0; valid = 1'b0; clr = 1'b0; m_ready = 1'b1;
        x2 = '0; valid2 = 1'b0; m_ready2 = 1'b1;
        step(); step();
        chk("reset m_valid", int'(m_valid), 0);
        chk("reset level", int'(level), 0);
        chk("reset ovf", int'(ovf), 0);
        chk("reset m_data", int'(m_data), 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 22; i++) begin
            x = 16'(vecs[i].xin); valid = vecs[i].v; m_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d m_valid", i), int'(m_valid), int'(vecs[i].ev));
            if (vecs[i].ev)
                chk($sformatf("vec%0d m_data", i), int'(m_data), vecs[i].ed);
            chk($sformatf("vec%0d level", i), int'(level), vecs[i].el);
        end
        valid = 1'b0;

        // saturation with SHIFT=0
        for (int i = 0; i < 4; i++) begin
            x2 = 16'sh7fff; valid2 = 1'b1; step();
        end
        valid2 = 1'b0;
        chk("sat pos m_valid", int'(m_valid2), 1);
        chk("sat pos m_data", int'(m_data2), 32767);
        for (int i = 0; i < 4; i++) begin
            x2 = 16'sh8000; valid2 = 1'b1; step();
        end
        valid2 = 1'b0;
        chk("sat neg m_valid", int'(m_valid2), 1);
        chk("sat neg m_data", int'(m_data2), -32768);
        step();
        chk("sat drained", int'(m_valid2), 0);

        // overflow: 9 blocks into a depth-8 FIFO with no pops
        m_ready = 1'b0;
        for (int b = 0; b < 8; b++) send_block(4, 4, 4, 4);
        chk("fill level", int'(level), 8);
        chk("fill ovf", int'(ovf), 0);
        send_block(4, 4, 4, 4);
        chk("drop level", int'(level), 8);
        chk("drop ovf", int'(ovf), 1);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d data", i), int'(m_data), 4);
            step();
        end
        chk("drain level", int'(level), 0);
        chk("drain m_valid", int'(m_valid), 0);
        chk("ovf sticky", int'(ovf), 1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr ovf", int'(ovf), 0);

        // full FIFO, push edge coincides with a pop
        m_ready = 1'b0;
        for (int b = 0; b < 8; b++) send_block(4, 4, 4, 4);
        for (int i = 0; i < 3; i++) begin
            x = 16'sd4; valid = 1'b1; step();
        end
        x = 16'sd4; valid = 1'b1; m_ready = 1'b1; step();
        valid = 1'b0; m_ready = 1'b0;
        chk("pushpop level", int'(level), 8);
        chk("pushpop ovf", int'(ovf), 0);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr level", int'(level), 0);

        // clr on the closing sample of a block suppresses the push and restarts phase
        m_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            x = 16'(i); valid = 1'b1; step();
        end
        x = 16'sd4; valid = 1'b1; clr = 1'b1; step();
        clr = 1'b0; valid = 1'b0;
        chk("clr nopush", int'(m_valid), 0);
        send_block(1, 2, 3, 4);
        chk("after clr m_valid", int'(m_valid), 1);
        chk("after clr m_data", int'(m_data), r1);
        step();

        // async reset mid-block with data held in FIFO
        m_ready = 1'b0;
        send_block(1, 2, 3, 4);
        chk("pre rst level", int'(level), 1);
        x = 16'sd1; valid = 1'b1; step();
        x = 16'sd2; step();
        valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async m_valid", int'(m_valid), 0);
        chk("async level", int'(level), 0);
        chk("async m_data", int'(m_data), 0);
        chk("async ovf", int'(ovf), 0);
        step();
        rst = 1'b1;
        m_ready = 1'b1;
        send_block(1, 2, 3, 4);
        chk("post rst m_valid", int'(m_valid), 1);
        chk("post rst m_data", int'(m_data), r1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameter DECIM, default 4, decimation factor; legal range 2..16.
REQ-002 Parameter SHIFT, default 2, arithmetic right shift applied to each block sum; legal range 0..8.
REQ-003 Parameter DEPTH, default 8, output FIFO depth in entries; must be a power of 2, 2..64.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset), released synchronously by the integrator.
REQ-006 x  input  16  signed FIR output sample (two's complement).
REQ-007 valid  input  1  x is valid this cycle; no backpressure to upstream.
REQ-008 clr  input  1  synchronous flush of phase, accumulator, FIFO and ovf.
REQ-009 m_data  output  16  signed decimated sample at FIFO head.
REQ-010 m_valid  output  1  FIFO non-empty.
REQ-011 m_ready  input  1  downstream accepts m_data this cycle.
REQ-012 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 ovf  output  1  sticky flag: a decimated result was dropped because the FIFO was full.

Function
REQ-014 Phase counter 0..DECIM-1 advances only on edges with valid=1 and wraps to 0 after DECIM-1.
REQ-015 Accumulator width 17+clog2(DECIM) bits, signed; at phase 0 it loads sign-extended x, otherwise it adds x.
REQ-016 On the edge sampling the DECIM-th valid input (phase DECIM-1), sum = acc + x; then result = (sum + rnd) >>> SHIFT, where rnd is defined in REQ-027/028.
REQ-017 Result saturates to [-32768, 32767] before entering the FIFO.
REQ-018 Push occurs on the same edge as REQ-016; m_valid rises in the following cycle when the FIFO was empty (latency 1 cycle from the last input edge).
REQ-019 FIFO is first-word-fall-through; a pop occurs on an edge with m_valid=1 and m_ready=1.
REQ-020 Push while full with simultaneous pop: both succeed, level unchanged, no drop.
REQ-021 Push while full without pop: result dropped, FIFO unchanged, ovf set to 1 on that edge.
REQ-022 Pop while empty is ignored; m_data is don't-care while m_valid=0.
REQ-023 Gaps in valid hold phase and acc unchanged; a block may span any number of cycles.
REQ-024 clr=1 overrides all other activity on that edge: phase=0, acc=0, FIFO empty, ovf=0, and no push or pop occurs.

Reset
REQ-025 While rst=0: phase=0, acc=0, FIFO pointers=0, level=0, m_valid=0, ovf=0, m_data=0; a partial block is discarded.
REQ-026 The first valid input after reset release is phase 0.

Configuration
REQ-027 Macro FIR_DECIM_ROUND_EN defined: rnd = 2^(SHIFT-1) when SHIFT>0, else 0 (round half up).
REQ-028 Macro FIR_DECIM_ROUND_EN undefined: rnd = 0 (truncation toward negative infinity); no rounding adder is synthesized.

Verification
REQ-029 Defaults, m_ready=1, x=1..8 on consecutive valid cycles -> outputs 3, 7 with ROUND_EN, or 2, 6 without; each appears 1 cycle after inputs 4 and 8.
REQ-030 SHIFT=0, four samples of 32767 -> m_data=32767 (saturated); four samples of -32768 -> m_data=-32768.
REQ-031 Defaults, x=1..4 with valid=0 idle cycles between samples -> single output 3 (ROUND_EN), 1 cycle after the 4th sample.
REQ-032 m_ready=0, 9 blocks of four 4s (each block yields 4) -> level=8, ovf=1 after the 9th block; set m_ready=1 -> eight 4s drain, ovf stays 1 until clr.
REQ-033 FIFO full with m_ready=1 on the push edge -> level stays 8, ovf stays 0.
REQ-034 rst=0 asserted after 2 inputs of a block -> all outputs 0 immediately (asynchronous); after release, x=1..4 -> output 3 (ROUND_EN).
